// File: rtl/cores_dout_arbiter.sv
// cores_dout_arbiter
// Round-robin drain of per-core nibble output buffers. Each result record is
// read nibble by nibble; EQUAL records are packed into a 32-bit word for the
// host output FIFO, BATCH_COMPLETE reports are collected into a mask that
// fires a one-cycle batch_done once every core has reported.
module cores_dout_arbiter #(
    parameter int N_CORES = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_CORES-1:0]     core_empty,
    input  logic [4*N_CORES-1:0]   core_dout,
    output logic [N_CORES-1:0]     core_rd_en,
    output logic [31:0]            out_data,
    output logic                   out_wr_en,
    input  logic                   out_full,
    output logic                   batch_done,
    output logic                   err
);

    localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [PW-1:0]      ptr_reg, ptr_next;
    logic [2:0]         idx_reg, idx_next;
    logic [11:0]        payload_reg, payload_next;   // n2..n4 while the record streams in
    logic               bc_reg, bc_next;             // BATCH_COMPLETE of the record being handled
    logic [31:0]        data_reg, data_next;
    logic [N_CORES-1:0] mask_reg, mask_next;
    logic               bd_reg, bd_next;
    logic               err_reg, err_next;

    logic [3:0]         cur_nib;
    logic               cur_empty;
    logic [N_CORES-1:0] ptr_onehot;
    logic [PW-1:0]      ptr_inc;
    logic               set_done;
    logic [N_CORES-1:0] mask_merged;

    // one-hot decode of the core currently pointed at
    generate
        for (genvar gi = 0; gi < N_CORES; gi++) begin : g_sel
            assign ptr_onehot[gi] = (ptr_reg == PW'(gi));
        end
    endgenerate

    assign core_rd_en = (state_reg == READ) ? ptr_onehot : '0;
    assign ptr_inc    = (ptr_reg == PW'(N_CORES - 1)) ? '0 : ptr_reg + 1'b1;
    assign out_data   = data_reg;
    assign batch_done = bd_reg;
    assign err        = err_reg;

    // mux out the nibble and empty flag of the selected core
    always_comb begin
        cur_nib   = 4'h0;
        cur_empty = 1'b1;
        for (int i = 0; i < N_CORES; i++) begin
            if (ptr_reg == PW'(i)) begin
                cur_nib   = core_dout[4*i +: 4];
                cur_empty = core_empty[i];
            end
        end
    end

    // next-state, record parsing and write strobe
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        idx_next     = idx_reg;
        payload_next = payload_reg;
        bc_next      = bc_reg;
        data_next    = data_reg;
        err_next     = err_reg;
        set_done     = 1'b0;
        out_wr_en    = 1'b0;
        case (state_reg)
            SCAN: begin
                if (!cur_empty) begin
                    state_next = READ;
                    idx_next   = 3'd0;
                end else begin
                    ptr_next = ptr_inc;
                end
            end
            READ: begin
                if (cur_empty) begin
                    // buffer ran dry mid-record: abandon it
                    err_next   = 1'b1;
                    state_next = SCAN;
                    ptr_next   = ptr_inc;
                    idx_next   = 3'd0;
                end else begin
                    idx_next = idx_reg + 3'd1;
                    case (idx_reg)
                        3'd0: begin
                            if (!cur_nib[0]) err_next = 1'b1;
                        end
                        3'd1: begin
                            bc_next = cur_nib[0];
                            if (!cur_nib[1]) begin
                                // two-nibble record: only a BATCH_COMPLETE report is legal
                                if (cur_nib[0]) set_done = 1'b1;
                                else            err_next = 1'b1;
                                state_next = SCAN;
                                ptr_next   = ptr_inc;
                                idx_next   = 3'd0;
                            end
                        end
                        3'd5: begin
                            data_next  = {12'h000, 4'(ptr_reg), payload_reg, cur_nib};
                            state_next = WRITE;
                            idx_next   = 3'd0;
                        end
                        default: begin
                            payload_next = {payload_reg[7:0], cur_nib};
                        end
                    endcase
                end
            end
            WRITE: begin
                if (!out_full) begin
                    out_wr_en  = 1'b1;
                    set_done   = bc_reg;
                    state_next = SCAN;
                    ptr_next   = ptr_inc;
                end
            end
            default: begin
                state_next = SCAN;
            end
        endcase
    end

    // batch completion: fire and clear once every core has reported
    always_comb begin
        mask_merged = mask_reg | (set_done ? ptr_onehot : '0);
        if (&mask_merged) begin
            mask_next = '0;
            bd_next   = 1'b1;
        end else begin
            mask_next = mask_merged;
            bd_next   = 1'b0;
        end
    end

    // state registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg   <= SCAN;
            ptr_reg     <= '0;
            idx_reg     <= 3'd0;
            payload_reg <= 12'h000;
            bc_reg      <= 1'b0;
            data_reg    <= 32'h0;
            mask_reg    <= '0;
            bd_reg      <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            idx_reg     <= idx_next;
            payload_reg <= payload_next;
            bc_reg      <= bc_next;
            data_reg    <= data_next;
            mask_reg    <= mask_next;
            bd_reg      <= bd_next;
            err_reg     <= err_next;
        end
    end

endmodule

// File: tb/tb_cores_dout_arbiter.sv
// Bench for cores_dout_arbiter: per-core nibble buffers are modelled as queues,
// a record-level round-robin model predicts words, err and batch_done count.
module tb_cores_dout_arbiter;

    localparam int N = 8;

    logic             CLK;
    logic             RESET;
    logic [N-1:0]     core_empty;
    logic [4*N-1:0]   core_dout;
    logic [N-1:0]     core_rd_en;
    logic [31:0]      out_data;
    logic             out_wr_en;
    logic             out_full;
    logic             batch_done;
    logic             err;

    cores_dout_arbiter #(.N_CORES(N)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .core_empty (core_empty),
        .core_dout  (core_dout),
        .core_rd_en (core_rd_en),
        .out_data   (out_data),
        .out_wr_en  (out_wr_en),
        .out_full   (out_full),
        .batch_done (batch_done),
        .err        (err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0]  q    [N][$];     // buffer contents, front = current nibble
    logic [23:0] recq [N][$];     // records as {n0,n1,payload}
    logic [31:0] exp_words[$];
    logic        exp_err;
    int          exp_bd;
    int          exp_nib;

    int          bd_seen;
    int          rd_cnt;
    logic [N-1:0] rd_hist[$];
    logic         wr_hist[$];
    logic         bd_hist[$];
    logic [N-1:0] s_rd;
    logic         s_wr;
    logic [31:0]  s_data;
    logic         full_force;
    int           full_pct;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            core_empty[i]       = (q[i].size() == 0);
            core_dout[4*i +: 4] = (q[i].size() != 0) ? q[i][0] : 4'h0;
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add_rec(input int c, input logic [3:0] n0, input logic [3:0] n1,
                           input logic [15:0] pl);
        recq[c].push_back({n0, n1, pl});
        q[c].push_back(n0);
        q[c].push_back(n1);
        if (n1[1]) begin
            q[c].push_back(pl[15:12]);
            q[c].push_back(pl[11:8]);
            q[c].push_back(pl[7:4]);
            q[c].push_back(pl[3:0]);
        end
    endtask

    // record-level model: visit cores 0,1,2,... cyclically, one record per visit
    task automatic build_model();
        int pos[N];
        int c;
        int served;
        int total;
        logic [N-1:0] mask;
        logic [23:0] r;
        logic [3:0] n0, n1;
        exp_words.delete();
        exp_err = 1'b0;
        exp_bd  = 0;
        exp_nib = 0;
        total   = 0;
        for (int i = 0; i < N; i++) begin
            pos[i] = 0;
            total += recq[i].size();
        end
        c = 0;
        served = 0;
        mask = '0;
        while (served < total) begin
            if (pos[c] < recq[c].size()) begin
                r = recq[c][pos[c]];
                pos[c]++;
                served++;
                n0 = r[23:20];
                n1 = r[19:16];
                if (!n0[0]) exp_err = 1'b1;
                if (n1[1]) begin
                    exp_words.push_back({12'h000, 4'(c), r[15:0]});
                    exp_nib += 6;
                end else begin
                    exp_nib += 2;
                    if (!n1[0]) exp_err = 1'b1;
                end
                if (n1[0]) begin
                    mask[c] = 1'b1;
                    if (&mask) begin
                        exp_bd++;
                        mask = '0;
                    end
                end
            end
            c = (c + 1) % N;
        end
    endtask

    // one clock: sample at negedge, update buffers just after posedge
    task automatic tick();
        @(negedge CLK);
        s_rd   = core_rd_en;
        s_wr   = out_wr_en;
        s_data = out_data;
        chk("rd_onehot", 32'($countones(s_rd) <= 1), 32'd1);
        if (s_wr) begin
            $display("wr core=%0d data=%h", s_data[19:16], s_data);
            if (exp_words.size() == 0) chk("unexpected_wr", s_data, 32'hFFFF_FFFF);
            else                       chk("word", s_data, exp_words.pop_front());
        end
        if (batch_done) begin
            bd_seen++;
            $display("batch_done");
        end
        rd_cnt += $countones(s_rd);
        rd_hist.push_back(s_rd);
        wr_hist.push_back(s_wr);
        bd_hist.push_back(batch_done);
        @(posedge CLK);
        #1;
        if (!RESET) begin
            for (int i = 0; i < N; i++)
                if (s_rd[i] && q[i].size() != 0) void'(q[i].pop_front());
        end
        refresh();
        out_full = full_force || ($urandom_range(0, 99) < full_pct);
    endtask

    task automatic begin_scn();
        RESET      = 1'b1;
        full_force = 1'b0;
        full_pct   = 0;
        out_full   = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            recq[i].delete();
        end
        exp_words.delete();
        refresh();
        chk("rst_rd_en", 32'(core_rd_en), 32'd0);
        chk("rst_wr_en", 32'(out_wr_en), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_bd", 32'(batch_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    task automatic release_scn();
        build_model();
        refresh();
        tick();
        RESET = 1'b0;
        rd_hist.delete();
        wr_hist.delete();
        bd_hist.delete();
        bd_seen = 0;
        rd_cnt  = 0;
    endtask

    task automatic finish_scn(input string name);
        int n;
        n = 0;
        while ((!all_empty() || exp_words.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 3000), 32'd1);
        repeat (12) tick();
        chk("err", 32'(err), 32'(exp_err));
        chk("batch_done_cnt", 32'(bd_seen), 32'(exp_bd));
        chk("rd_nibbles", 32'(rd_cnt), 32'(exp_nib));
        chk("leftover_words", 32'(exp_words.size()), 32'd0);
        $display("scenario %s done: words/bd/err model %0d", name, exp_bd);
    endtask

    function automatic logic [3:0] good_n0();
        logic [3:0] v;
        v = 4'($urandom());
        v[0] = 1'b1;
        return v;
    endfunction

    initial begin
        int k;
        int m;
        int n;
        int kind;
        logic [3:0] n0;
        logic [3:0] n1;
        RESET = 1'b1;
        out_full = 1'b0;
        full_force = 1'b0;
        full_pct = 0;
        core_empty = '1;
        core_dout = '0;

        // single EQUAL record on core 3, cycle-exact
        begin_scn();
        add_rec(3, 4'h1, 4'h2, 16'hABCD);
        release_scn();
        finish_scn("single");
        k = -1;
        for (int i = 0; i < rd_hist.size(); i++) if (rd_hist[i] != 0 && k < 0) k = i;
        chk("t1_first_rd", 32'(k), 32'd4);
        if (k < 0) k = 0;
        for (int j = 0; j < 6; j++) chk("t1_rd", 32'(rd_hist[k+j]), 32'h08);
        chk("t1_rd_end", 32'(rd_hist[k+6]), 32'd0);
        chk("t1_wr_cycle", 32'(wr_hist[k+6]), 32'd1);

        // every core reports BATCH_COMPLETE only
        begin_scn();
        for (int c = 0; c < N; c++) add_rec(c, 4'h1, 4'h1, 16'h0);
        release_scn();
        finish_scn("batch");
        m = 0;
        for (int i = 0; i < rd_hist.size(); i++) if (rd_hist[i] == 8'h80) m = i;
        chk("t2_bd_timing", 32'(bd_hist[m+1]), 32'd1);

        // two cores with two EQUAL records each: round-robin order
        begin_scn();
        add_rec(1, 4'h1, 4'h2, 16'h1111);
        add_rec(1, 4'h1, 4'h2, 16'h1122);
        add_rec(5, 4'h1, 4'h2, 16'h5511);
        add_rec(5, 4'h1, 4'h2, 16'h5522);
        release_scn();
        finish_scn("fair");

        // output FIFO full while the word is pending
        begin_scn();
        full_force = 1'b1;
        out_full = 1'b1;
        add_rec(2, 4'h1, 4'h2, 16'h7E57);
        release_scn();
        n = 0;
        while (q[2].size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("stall_reach", 32'(n < 100), 32'd1);
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("stall_wr", 32'(s_wr), 32'd0);
            chk("stall_data", s_data, 32'h0002_7E57);
            chk("stall_rd", 32'(s_rd), 32'd0);
        end
        full_force = 1'b0;
        out_full = 1'b0;
        tick();
        chk("stall_release_wr", 32'(s_wr), 32'd1);
        finish_scn("stall");

        // bad start marker and non-EQUAL without BATCH_COMPLETE
        begin_scn();
        add_rec(0, 4'h0, 4'h1, 16'h0);
        add_rec(4, 4'h1, 4'h0, 16'h0);
        add_rec(6, 4'h3, 4'h2, 16'hBEEF);
        release_scn();
        finish_scn("errors");

        // reset in the middle of a record
        begin_scn();
        add_rec(3, 4'h1, 4'h2, 16'h1234);
        release_scn();
        n = 0;
        while (q[3].size() > 3 && n < 100) begin
            tick();
            n++;
        end
        chk("mid_reset_reach", 32'(n < 100), 32'd1);
        #1;
        RESET = 1'b1;
        #1;
        chk("mid_rst_rd_en", 32'(core_rd_en), 32'd0);
        chk("mid_rst_wr_en", 32'(out_wr_en), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        begin_scn();
        add_rec(3, 4'h1, 4'h2, 16'h5A5A);
        release_scn();
        finish_scn("after_reset");

        // randomized mixes
        for (int s = 0; s < 25; s++) begin
            begin_scn();
            full_pct = $urandom_range(0, 60);
            for (int c = 0; c < N; c++) begin
                if (s % 3 == 0) add_rec(c, good_n0(), 4'h1, 16'h0);
                for (int r = 0; r < $urandom_range(0, 3); r++) begin
                    kind = (s % 4 == 1) ? $urandom_range(0, 9) : $urandom_range(0, 7);
                    n1 = 4'($urandom());
                    n0 = good_n0();
                    if (kind <= 4)      n1[1] = 1'b1;
                    else if (kind <= 7) begin n1[1] = 1'b0; n1[0] = 1'b1; end
                    else if (kind == 8) n0[0] = 1'b0;
                    else                begin n1[1] = 1'b0; n1[0] = 1'b0; end
                    add_rec(c, n0, n1, 16'($urandom()));
                end
            end
            release_scn();
            finish_scn("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
